// File: rtl/mips_pkg.sv
// mips_pkg: shared types for the sequential MIPS multiply/divide unit
package mips_pkg;
  localparam int MULDIV_OP_WIDTH = 2;
  typedef enum logic [MULDIV_OP_WIDTH-1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } muldiv_op_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} muldiv_state_t;
endpackage

// File: rtl/mips_muldiv_core.sv
// mips_muldiv_core: radix-2 shift-add multiply / restoring divide datapath, one bit per step
// Divider step compiled in only with MIPS_MULDIV_DIV_EN.
module mips_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
`ifdef MIPS_MULDIV_DIV_EN
  logic div_q, fits;
  logic [WIDTH:0] shl;
  logic [WIDTH-1:0] diff;
  assign shl  = {hi, lo[WIDTH-1]};
  assign fits = shl >= {1'b0, mcand};
  // a successful trial leaves a remainder below the divisor, so WIDTH bits suffice
  assign diff = shl[WIDTH-1:0] - mcand;
  always_ff @(posedge clk) begin
    if (load) div_q <= is_div;
  end
`endif
  always_ff @(posedge clk) begin
    if (load) begin
      hi    <= '0;
      lo    <= is_div ? a : b;
      mcand <= is_div ? b : a;
    end else if (step) begin
`ifdef MIPS_MULDIV_DIV_EN
      if (div_q) {hi, lo} <= {fits ? diff : shl[WIDTH-1:0], lo[WIDTH-2:0], fits};
      else
`endif
      {hi, lo} <= {sum, lo[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: sequential MIPS MULT/MULTU/DIV/DIVU unit with sign handling and control FSM
// Define MIPS_MULDIV_DIV_EN to build the divider; otherwise divides complete at once with zero results.
module mips_muldiv_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef MIPS_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  muldiv_state_t state, state_n;
  muldiv_op_t op_q;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_q, mag_a, mag_b, core_hi, core_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;
  logic sgn, neg_a, neg_b, neg_q, neg_a_q, zero_q, accept, direct, fin;
  assign sgn    = op == MULT || op == DIV;
  assign neg_a  = sgn & operand_a[WIDTH-1];
  assign neg_b  = sgn & operand_b[WIDTH-1];
  assign mag_a  = neg_a ? -operand_a : operand_a;
  assign mag_b  = neg_b ? -operand_b : operand_b;
  assign accept = start && state != RUN;
  assign direct = !DIV_EN && op[1];
  assign fin    = state == RUN && cnt == '0;
  assign busy   = state == RUN;
  assign done   = state == DONE;
  assign prod   = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
  // divide by zero bypasses sign correction and returns the raw dividend in hi
  assign res_hi = !op_q[1] ? prod[2*WIDTH-1:WIDTH] : zero_q ? a_q : neg_a_q ? -core_hi : core_hi;
  assign res_lo = !op_q[1] ? prod[WIDTH-1:0] : zero_q ? '1 : neg_q ? -core_lo : core_lo;
  mips_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .load(accept),
    .step(busy && !fin),
    .is_div(op[1]),
    .a(mag_a),
    .b(mag_b),
    .hi(core_hi),
    .lo(core_lo)
  );
  always_comb begin
    state_n = state;
    if (accept) state_n = direct ? DONE : RUN;
    else if (state == DONE) state_n = IDLE;
    else if (fin) state_n = DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_hi      <= '0;
      out_lo      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_q    <= op;
      a_q     <= operand_a;
      zero_q  <= operand_b == '0;
      neg_q   <= neg_a ^ neg_b;
      neg_a_q <= neg_a;
      cnt     <= CW'(WIDTH);
      if (direct) {out_hi, out_lo, div_by_zero} <= '0;
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (fin) begin
        out_hi      <= res_hi;
        out_lo      <= res_lo;
        div_by_zero <= op_q[1] && zero_q;
      end
    end
  end
endmodule

// File: doc/mips_muldiv_seq.md
MIPS_MULDIV_SEQ -- requirements
Module: mips_muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width in bits.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port start  input  1  SHALL request an operation; it SHALL be sampled only while busy=0.
REQ-005 Port op  input  2  SHALL select the operation, type muldiv_op_t: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-006 Port operand_a  input  WIDTH  SHALL be the multiplicand or dividend (rs).
REQ-007 Port operand_b  input  WIDTH  SHALL be the multiplier or divisor (rt).
REQ-008 Port busy  output  1  SHALL be high while an accepted operation is in progress.
REQ-009 Port done  output  1  SHALL be a one-cycle pulse marking out_hi/out_lo valid.
REQ-010 Port out_hi  output  WIDTH  SHALL carry the product upper half or the remainder, feeding the HI register.
REQ-011 Port out_lo  output  WIDTH  SHALL carry the product lower half or the quotient, feeding the LO register.
REQ-012 Port div_by_zero  output  1  SHALL be high together with done when a DIV/DIVU had operand_b=0.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE or DONE with start=1 SHALL latch op and operands, load the cycle counter with WIDTH, and go to RUN.
REQ-015 DONE with start=0 SHALL go to IDLE; RUN with counter reaching 0 SHALL go to DONE.
REQ-016 busy SHALL be 1 in RUN only; start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-017 Latency: start accepted at edge N SHALL give done=1 in the cycle after edge N+WIDTH+1 (33 cycles at WIDTH=32); back-to-back starts in DONE SHALL be legal.
REQ-018 Multiply SHALL be radix-2 shift-add, one bit per RUN cycle, producing a 2*WIDTH product {out_hi,out_lo}.
REQ-019 Divide SHALL be radix-2 restoring, one quotient bit per RUN cycle: out_lo=quotient, out_hi=remainder.
REQ-020 Signed ops SHALL operate on absolute values, then negate: product if sign_a^sign_b, quotient if sign_a^sign_b, remainder if sign_a.
REQ-021 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL return lo=0x80000000, hi=0, with no flag.
REQ-022 Divide by zero SHALL take normal latency and give lo=all ones, hi=operand_a unmodified, no sign correction, div_by_zero=1.
REQ-023 out_hi, out_lo and div_by_zero SHALL update only on entry to DONE and hold until the next DONE.

Reset
REQ-024 rst=1 at any edge, including mid-RUN, SHALL force IDLE, busy=0, done=0, out_hi=0, out_lo=0, div_by_zero=0 and abandon the operation.

Configuration
REQ-025 Macro MIPS_MULDIV_DIV_EN defined SHALL compile in the divider datapath per REQ-019..REQ-022.
REQ-026 Without MIPS_MULDIV_DIV_EN, DIV/DIVU SHALL go IDLE to DONE directly (done one cycle after accept) with out_hi=out_lo=0 and div_by_zero=0; multiply SHALL be unchanged.

Structure
REQ-027 muldiv_op_t, its encodings, the MULDIV_OP_WIDTH=2 constant and the FSM state enum SHALL live in mips_pkg.
REQ-028 The shift/add-subtract datapath SHALL be one sub-module, mips_muldiv_core, shared by multiply and divide; the FSM and sign handling SHALL stay in mips_muldiv_seq.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-032 DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 with done; without the macro -> done after 1 cycle, hi=lo=0.
REQ-033 start pulsed at cycle 5 of RUN with different operands -> first result unchanged; start held in DONE -> second operation accepted back-to-back.
REQ-034 rst asserted at cycle 10 of RUN -> busy=0, done=0, outputs 0 after that edge, no done pulse follows.
